demux_stream_n: RTL
===================

// Module: demux_stream_n
// PURPOSE
//  Parametrised 1-to-NUM_CH stream demultiplexer with a valid/ready handshake.
//  Each beat is routed on in_sel and captured in a one-entry output register per channel.
//  Successor to the combinational 2x4 demux; used wherever a single producer feeds several consumers.
//  Routing is registered: one-cycle latency. A stalled channel does not block traffic to other channels.
// PARAMETERS
//  DATA_W  8  payload width in bits (>=1)
//  NUM_CH  4  number of output channels (2..16; need not be a power of 2)
//  SEL_W   localparam = (NUM_CH>1) ? $clog2(NUM_CH) : 1; width of in_sel
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous active-high reset
//  in_valid   in   1              input beat valid
//  in_ready   out  1              input beat accepted this cycle when in_valid & in_ready
//  in_data    in   DATA_W         input payload
//  in_sel     in   SEL_W          destination channel index
//  in_bcast   in   1              broadcast request (present only with DEMUX_BCAST_EN)
//  out_valid  out  NUM_CH         per-channel valid; bit k = channel k
//  out_ready  in   NUM_CH         per-channel ready from consumers
//  out_data   out  NUM_CH*DATA_W  channel k payload at [k*DATA_W +: DATA_W]
//  sel_err    out  1              one-cycle pulse: an out-of-range beat was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, sel_err=0.
//  - Channel k free_k = ~out_valid[k] | out_ready[k].
//  - Unicast in_ready = free_{in_sel} (combinational; no dependency on in_valid).
//  - Accept: in_valid & in_ready -> on the next edge out_valid[in_sel]=1, out_data slice=in_data.
//  - Channel drain: out_valid[k] & out_ready[k] with no load to k -> out_valid[k]=0 next edge.
//    out_data keeps its last value.
//  - Simultaneous drain and load on channel k: the new beat replaces the old one.
//    out_valid[k] stays 1. No bubble: full throughput per channel.
//  - Out-of-range sel (in_sel >= NUM_CH): in_ready=1, no channel is loaded.
//    sel_err=1 for exactly one cycle after the accept edge.
//  - Registered channel data is held stable while out_valid[k]=1 and out_ready[k]=0.
//  - Stalled channels do not affect in_ready for beats addressed to free channels.
//  - in_data and in_sel are ignored when in_valid=0. No state changes except drains.
//  - Reset mid-transfer: all pending beats are discarded. No output glitches beyond the async clear.
// CONFIGURATION
//  DEMUX_BCAST_EN defined:
//  - in_bcast port exists.
//  - When in_bcast=1, in_sel is ignored and in_ready = AND of free_k over all channels.
//  - An accepted beat loads every channel with in_data in the same edge.
//  - sel_err is never raised for broadcast beats.
//  DEMUX_BCAST_EN undefined:
//  - No in_bcast port; unicast-only behaviour as above.
// TESTING (DATA_W=8, NUM_CH=4 unless noted)
//  1 Reset:
//    - Stimulus: rst=1 mid-run with all channels valid.
//    - Response: out_valid=4'b0000, out_data=0, sel_err=0 immediately, without a clock edge.
//  2 Routing:
//    - Stimulus: sel=0..3, data=8'hA0..8'hA3, all out_ready=1.
//    - Response: each beat appears on its channel one cycle later. in_ready stays 1.
//  3 Back-pressure isolation:
//    - Stimulus: out_ready[2]=0, two beats to ch2 (8'h55 then 8'h66), then a beat to ch1.
//    - Response: ch2 holds 8'h55 and in_ready=0 while sel=2. The ch1 beat is accepted.
//  4 Drain+load:
//    - Stimulus: ch0 holds 8'h11 with out_ready[0]=1; 8'h22 to ch0 in the same cycle.
//    - Response: out_valid[0] stays 1 and out_data ch0=8'h22.
//  5 Bad sel:
//    - Stimulus: NUM_CH=3, sel=2'd3, data=8'hFF.
//    - Response: in_ready=1, no out_valid change, sel_err pulses for one cycle.
//  6 Broadcast (DEMUX_BCAST_EN):
//    - Stimulus: in_bcast=1, data=8'h5A.
//    - Response: with out_ready[3]=0 and ch3 full, in_ready=0. After ch3 drains, all 4 channels hold 8'h5A.

Source files
------------

// File: rtl/demux_stream_n.sv
// demux_stream_n: 1-to-NUM_CH valid/ready stream demultiplexer.
// Every channel has a one-entry output register, so routing takes one cycle
// and a stalled channel never blocks beats addressed to the other channels.
// Beats whose in_sel is out of range are accepted, dropped, and flagged on sel_err.
// Optional feature macro: DEMUX_BCAST_EN adds the in_bcast port. A beat with
// in_bcast=1 loads all channels at once and waits until every channel is free.
module demux_stream_n #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     sel_err
);

  // The extra top bit lets the range compare hold NUM_CH even when NUM_CH is a power of 2.
  localparam logic [SEL_W:0] LP_NUM_CH = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0]        r_valid;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic                     r_sel_err;

  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_load;
  logic              w_sel_oob;
  logic              w_bcast;
  logic              w_ready_uc;
  logic              w_accept;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A channel can take a new beat if it is empty or is being drained this cycle.
  assign w_free    = ~r_valid | out_ready;
  assign w_sel_oob = ({1'b0, in_sel} >= LP_NUM_CH);

  // Decode in_sel into a one-hot channel select. An out-of-range index selects nothing.
  always_comb begin
    // NOTE: give every always_comb output a default first. Then no path leaves it unassigned, and no latch is inferred.
    w_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_hit[k] = ({1'b0, in_sel} == (SEL_W+1)'(k));
    end
  end

  // in_ready depends only on the selected channel or channels, never on in_valid.
  assign w_ready_uc = w_sel_oob | (|(w_hit & w_free));
  assign in_ready   = w_bcast ? (&w_free) : w_ready_uc;
  assign w_accept   = in_valid & in_ready;
  assign w_load     = !w_accept ? '0 : (w_bcast ? '1 : w_hit);

  // Per-channel holding registers. A load takes priority over a drain, so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_data    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        // NOTE: sequential state uses non-blocking assignments. Every register then samples values from before the edge, whatever the statement order.
        if (w_load[k]) begin
          r_valid[k]                  <= 1'b1;
          r_data[k*DATA_W +: DATA_W]  <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      r_sel_err <= w_accept & ~w_bcast & w_sel_oob;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign sel_err   = r_sel_err;

endmodule
